// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
package md_pkg;

  localparam int OP_W             = 3;
  localparam int MULT_CYCLES_DEF  = 5;
  localparam int DIV_CYCLES_DEF   = 10;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: 64-bit products, quotient/remainder, divide-by-zero flag.
module md_arith
  import md_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_dvsr_s;
  logic [31:0] w_dvsr_u;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic        w_b_zero;

  assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  assign w_b_zero = (b == '0);
  assign w_mag_a  = a[31] ? (~a + 32'd1) : a;
  assign w_mag_b  = b[31] ? (~b + 32'd1) : b;
  assign w_dvsr_s = w_b_zero ? 32'd1 : w_mag_b;
  assign w_dvsr_u = w_b_zero ? 32'd1 : b;
  assign w_q_mag  = w_mag_a / w_dvsr_s;
  assign w_r_mag  = w_mag_a % w_dvsr_s;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    div0   = 1'b0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = w_prod_s;
      OP_MULTU: {res_hi, res_lo} = w_prod_u;
      OP_DIV: begin
        div0   = w_b_zero;
        res_lo = (a[31] ^ b[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
        res_hi = a[31] ? (~w_r_mag + 32'd1) : w_r_mag;
      end
      OP_DIVU: begin
        div0   = w_b_zero;
        res_lo = a / w_dvsr_u;
        res_hi = a % w_dvsr_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multi-cycle HI/LO unit: FSM, busy counter, operand latches and architectural HI/LO.
module md_unit_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  input  logic            md_use_d,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic            busy,
  output logic            stall
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;
  md_op_e            r_op;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;
  logic [31:0]       w_res_hi;
  logic [31:0]       w_res_lo;
  logic              w_div0;

  md_arith u_arith (
    .op     (r_op),
    .a      (r_a),
    .b      (r_b),
    .res_hi (w_res_hi),
    .res_lo (w_res_lo),
    .div0   (w_div0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_MULT;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                r_op    <= md_op_e'(op);
                r_a     <= a;
                r_b     <= b;
                r_cnt   <= CNT_W'(MULT_CYCLES);
                r_state <= ST_BUSY;
              end
              OP_DIV, OP_DIVU: begin
                r_op    <= md_op_e'(op);
                r_a     <= a;
                r_b     <= b;
                r_cnt   <= CNT_W'(DIV_CYCLES);
                r_state <= ST_BUSY;
              end
              OP_MTHI: r_hi <= a;
              OP_MTLO: r_lo <= a;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          // Last busy cycle commits the result; divide-by-zero leaves HI/LO alone.
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            if (!w_div0) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = (r_state == ST_BUSY);
  assign stall = ((start & (op <= 3'd3)) | busy) & md_use_d;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed scoreboard bench for md_unit_ctrl: latency, results, stall, reset and ignore cases.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_d;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb_q[$];
  logic [63:0] m_hl;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .md_use_d (md_use_d),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour built on 64-bit longint arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] prev);
    longint sx;
    longint sy;
    longint q;
    longint r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: return 64'(sx * sy);
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) return prev;
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (y == 32'd0) return prev;
        return {x % y, x / y};
      end
      default: return prev;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int n);
    int c;
    logic [63:0] exp;
    exp  = model(o, x, y, m_hl);
    m_hl = exp;
    sb_q.push_back(exp);
    op = o; a = x; b = y; start = 1'b1; md_use_d = 1'b1;
    #1;
    check({tag, "_stall_start"}, 64'(stall), 64'(1));
    tick();
    start = 1'b0;
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      a = $urandom; b = $urandom; md_use_d = 1'($urandom_range(0, 1));
      #1;
      check({tag, "_stall_busy"}, 64'(stall), 64'(md_use_d));
      tick();
      c++;
    end
    check({tag, "_busy_len"}, 64'(c), 64'(n));
    check({tag, "_result"}, {hi, lo}, sb_q.pop_front());
  endtask

  task automatic mt(input string tag, input logic [2:0] o, input logic [31:0] x);
    op = o; a = x; start = 1'b1; md_use_d = 1'b0;
    #1;
    check({tag, "_stall"}, 64'(stall), 64'(0));
    tick();
    start = 1'b0;
    if (o == 3'd4) m_hl[63:32] = x;
    else           m_hl[31:0]  = x;
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_hilo"}, {hi, lo}, m_hl);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; md_use_d = 1'b1;
    m_hl = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 5);
    check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("divu_7_2", 3'd3, 32'd7, 32'd2, 10);
    check("divu_const", {hi, lo}, {32'd1, 32'd3});
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 10);
    check("div_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    mt("mthi_11", 3'd4, 32'h11);
    mt("mtlo_22", 3'd5, 32'h22);
    run_op("div_by0", 3'd2, 32'd5, 32'd0, 10);
    check("div0_const", {hi, lo}, {32'h11, 32'h22});
    run_op("divu_by0", 3'd3, 32'd9, 32'd0, 10);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check("div_ovf_const", {hi, lo}, {32'h0, 32'h8000_0000});
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 10);
    for (int i = 0; i < 4; i++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 3));
      run_op("rand", ro, $urandom, $urandom, (ro <= 3'd1) ? 5 : 10);
    end

    // Second start while busy must be ignored; stall tracks busy with md_use_d held high.
    begin
      logic [63:0] exp;
      exp = model(3'd0, 32'd3, 32'hFFFF_FFFB, m_hl);
      m_hl = exp;
      sb_q.push_back(exp);
      op = 3'd0; a = 32'd3; b = 32'hFFFF_FFFB; start = 1'b1; md_use_d = 1'b1;
      #1;
      check("s2_stall_t0", 64'(stall), 64'(1));
      for (int i = 1; i <= 5; i++) begin
        tick();
        start = (i == 2);
        a = 32'h7; b = 32'h7;
        #1;
        check("s2_stall", 64'(stall), 64'(1));
        check("s2_busy", 64'(busy), 64'(1));
      end
      start = 1'b0;
      tick();
      check("s2_busy_end", 64'(busy), 64'(0));
      check("s2_stall_end", 64'(stall), 64'(0));
      check("s2_result", {hi, lo}, sb_q.pop_front());
    end

    // Ops 6 and 7 are no-ops.
    for (int i = 6; i <= 7; i++) begin
      op = 3'(i); a = 32'hDEAD_BEEF; b = 32'd1; start = 1'b1; md_use_d = 1'b1;
      #1;
      check("nop_stall", 64'(stall), 64'(0));
      tick();
      start = 1'b0;
      check("nop_busy", 64'(busy), 64'(0));
      check("nop_hilo", {hi, lo}, m_hl);
    end

    // Reset in the middle of a divide discards it.
    op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1; md_use_d = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hl = '0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_stall", 64'(stall), 64'(0));
    mt("mtlo_5a", 3'd5, 32'h5A);

    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
    tick();
    reset = 1'b0; start = 1'b0;
    m_hl = '0;
    check("rst_prio_busy", 64'(busy), 64'(0));
    check("rst_prio_hilo", {hi, lo}, 64'd0);

    mt("mthi_1234", 3'd4, 32'h1234);
    md_use_d = 1'b1;
    tick();
    check("mthi_idle_busy", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
